ysyx_22041071_ex_stage: RTL and testbench

//  Execute stage of the RV64 in-order pipeline. Consumes the ID/EX register outputs (operands, ALU op, dest, control).

---
 rtl/ysyx_22041071_pkg.sv | 30 +++
 rtl/ysyx_22041071_divider.sv | 101 ++++++++++
 rtl/ysyx_22041071_ex_stage.sv | 138 +++++++++++++
 tb/tb_ysyx_22041071_ex_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, divider states, datapath width.
package ysyx_22041071_pkg;
  localparam int XLEN     = 64;
  localparam int DIV_ITER = 64;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLL   = 5'd2,  ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,  ALU_XOR   = 5'd5,  ALU_SRL   = 5'd6,  ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,  ALU_AND   = 5'd9,  ALU_ADDW  = 5'd10, ALU_SUBW  = 5'd11,
    ALU_SLLW  = 5'd12, ALU_SRLW  = 5'd13, ALU_SRAW  = 5'd14, ALU_MUL   = 5'd15,
    ALU_MULW  = 5'd16, ALU_DIV   = 5'd17, ALU_DIVU  = 5'd18, ALU_REM   = 5'd19,
    ALU_REMU  = 5'd20, ALU_DIVW  = 5'd21, ALU_DIVUW = 5'd22, ALU_REMW  = 5'd23,
    ALU_REMUW = 5'd24, ALU_BEQ   = 5'd25, ALU_BNE   = 5'd26, ALU_BLT   = 5'd27,
    ALU_BGE   = 5'd28, ALU_BLTU  = 5'd29, ALU_BGEU  = 5'd30
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMUW);
  endfunction
endpackage

// File: rtl/ysyx_22041071_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms; one quotient bit per cycle.
module ysyx_22041071_divider
  import ysyx_22041071_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            accept,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);
  localparam int CNT_W = 7;

  div_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] dvd, rem, dvs;
  logic            neg_q, neg_r, is_w, is_rem;

  logic            in_w, in_signed, in_rem, sign_a, sign_b, b_zero;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, dvd_load;
  logic [XLEN:0]   trial;
  logic            qbit;
  logic [XLEN-1:0] q_fix, r_fix, sel;

  assign in_w      = (op == ALU_DIVW) || (op == ALU_DIVUW) || (op == ALU_REMW) || (op == ALU_REMUW);
  assign in_signed = (op == ALU_DIV) || (op == ALU_REM) || (op == ALU_DIVW) || (op == ALU_REMW);
  assign in_rem    = (op == ALU_REM) || (op == ALU_REMU) || (op == ALU_REMW) || (op == ALU_REMUW);

  // W operands are widened first so one magnitude path serves both widths.
  assign a_ext  = in_w ? (in_signed ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
  assign b_ext  = in_w ? (in_signed ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
  assign sign_a = in_signed & a_ext[XLEN-1];
  assign sign_b = in_signed & b_ext[XLEN-1];
  assign abs_a  = sign_a ? -a_ext : a_ext;
  assign abs_b  = sign_b ? -b_ext : b_ext;
  assign b_zero = (b_ext == '0);
  assign dvd_load = in_w ? {abs_a[31:0], 32'b0} : abs_a;

  assign trial = {rem, dvd[XLEN-1]} - {1'b0, dvs};
  assign qbit  = ~trial[XLEN];

  assign q_fix  = neg_q ? -dvd : dvd;
  assign r_fix  = neg_r ? -rem : rem;
  assign sel    = is_rem ? r_fix : q_fix;
  assign result = is_w ? sext32(sel[31:0]) : sel;

  assign stall     = ((state == DIV_IDLE) && start) || (state == DIV_RUN);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      dvd    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_w   <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            cnt    <= '0;
            dvs    <= abs_b;
            neg_r  <= sign_a;
            is_w   <= in_w;
            is_rem <= in_rem;
            if (b_zero) begin
              // All-ones quotient, dividend as remainder, no iteration needed.
              dvd   <= '1;
              rem   <= abs_a;
              neg_q <= 1'b0;
              state <= DIV_DONE;
            end else begin
              dvd   <= dvd_load;
              rem   <= '0;
              neg_q <= sign_a ^ sign_b;
              state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          dvd <= {dvd[XLEN-2:0], qbit};
          rem <= qbit ? trial[XLEN-1:0] : {rem[XLEN-2:0], dvd[XLEN-1]};
          cnt <= cnt + 1'b1;
          if (cnt == (is_w ? CNT_W'(31) : CNT_W'(DIV_ITER - 1))) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (accept) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ysyx_22041071_ex_stage.sv
// RV64 execute stage: inline ALU/MUL/branch, iterative divider, EX/MEM pipeline register.
module ysyx_22041071_ex_stage
  import ysyx_22041071_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic [63:0] pc_i,
  input  logic [31:0] ins_i,
  input  logic        brch_i,
  input  logic        mem_w_en_i,
  input  logic        wb_sel_i,
  input  logic [4:0]  alu_ctrl_i,
  input  logic        reg_w_en_i,
  input  logic [4:0]  rdest_i,
  input  logic [63:0] src_a_i,
  input  logic [63:0] src_b_i,
  input  logic [63:0] rt_data_i,
  input  logic [11:0] bimm_i,
  output logic [63:0] fwd_result,
  output logic        fwd_wen,
  output logic [4:0]  fwd_rdest,
  output logic        br_taken,
  output logic [63:0] br_target,
  output logic [63:0] pc_o,
  output logic [31:0] ins_o,
  output logic        mem_w_en_o,
  output logic        wb_sel_o,
  output logic        reg_w_en_o,
  output logic [4:0]  rdest_o,
  output logic [63:0] result_o,
  output logic [63:0] rt_data_o,
  output logic [1:0]  div_state
);
  alu_ctrl_t   op;
  logic        div_stall, br_cond;
  logic [63:0] div_result, alu_res, mul_lo, sra64;
  logic [31:0] a32, b32, sraw32, mulw32;

  assign op  = alu_ctrl_t'(alu_ctrl_i);
  assign a32 = src_a_i[31:0];
  assign b32 = src_b_i[31:0];
  assign mul_lo = src_a_i * src_b_i;
  assign mulw32 = a32 * b32;
  assign sra64  = $signed(src_a_i) >>> src_b_i[5:0];
  assign sraw32 = $signed(a32) >>> src_b_i[4:0];

  ysyx_22041071_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (valid_i & is_div_op(alu_ctrl_i)),
    .accept    (valid_i & ready_i),
    .op        (alu_ctrl_i),
    .a         (src_a_i),
    .b         (src_b_i),
    .stall     (div_stall),
    .result    (div_result),
    .state_dbg (div_state)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:  alu_res = src_a_i + src_b_i;
      ALU_SUB:  alu_res = src_a_i - src_b_i;
      ALU_SLL:  alu_res = src_a_i << src_b_i[5:0];
      ALU_SLT:  alu_res = {63'b0, $signed(src_a_i) < $signed(src_b_i)};
      ALU_SLTU: alu_res = {63'b0, src_a_i < src_b_i};
      ALU_XOR:  alu_res = src_a_i ^ src_b_i;
      ALU_SRL:  alu_res = src_a_i >> src_b_i[5:0];
      ALU_SRA:  alu_res = sra64;
      ALU_OR:   alu_res = src_a_i | src_b_i;
      ALU_AND:  alu_res = src_a_i & src_b_i;
      ALU_ADDW: alu_res = sext32(a32 + b32);
      ALU_SUBW: alu_res = sext32(a32 - b32);
      ALU_SLLW: alu_res = sext32(a32 << src_b_i[4:0]);
      ALU_SRLW: alu_res = sext32(a32 >> src_b_i[4:0]);
      ALU_SRAW: alu_res = sext32(sraw32);
      ALU_MUL:  alu_res = mul_lo;
      ALU_MULW: alu_res = sext32(mulw32);
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW: alu_res = div_result;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (op)
      ALU_BEQ:  br_cond = (src_a_i == src_b_i);
      ALU_BNE:  br_cond = (src_a_i != src_b_i);
      ALU_BLT:  br_cond = ($signed(src_a_i) < $signed(src_b_i));
      ALU_BGE:  br_cond = ($signed(src_a_i) >= $signed(src_b_i));
      ALU_BLTU: br_cond = (src_a_i < src_b_i);
      ALU_BGEU: br_cond = (src_a_i >= src_b_i);
      default:  br_cond = 1'b0;
    endcase
  end

  // Handshake: an instruction leaves EX only when valid_i & ready_o; while
  // ready_o is low upstream holds every input stable, and the EX/MEM
  // register is frozen whenever ready_i is low.
  assign ready_o    = ready_i & ~div_stall;
  assign fwd_result = alu_res;
  assign fwd_wen    = valid_i & reg_w_en_i & ~div_stall;
  assign fwd_rdest  = rdest_i;
  assign br_taken   = valid_i & ready_o & brch_i & br_cond;
  assign br_target  = pc_i + {{51{bimm_i[11]}}, bimm_i, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      ins_o      <= '0;
      mem_w_en_o <= 1'b0;
      wb_sel_o   <= 1'b0;
      reg_w_en_o <= 1'b0;
      rdest_o    <= '0;
      result_o   <= '0;
      rt_data_o  <= '0;
    end else if (ready_i) begin
      valid_o <= valid_i & ~div_stall;
      if (valid_i & ~div_stall) begin
        pc_o       <= pc_i;
        ins_o      <= ins_i;
        mem_w_en_o <= mem_w_en_i;
        wb_sel_o   <= wb_sel_i;
        reg_w_en_o <= reg_w_en_i;
        rdest_o    <= rdest_i;
        result_o   <= alu_res;
        rt_data_o  <= rt_data_i;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22041071_ex_stage.sv
// Directed bench for the execute stage: ALU, branches, stalls, divider corner cases and reset abort.
module tb_ysyx_22041071_ex_stage;
  import ysyx_22041071_pkg::*;

  logic        clk, reset, valid_i, ready_o, valid_o, ready_i;
  logic [63:0] pc_i, src_a_i, src_b_i, rt_data_i, fwd_result, br_target;
  logic [63:0] pc_o, result_o, rt_data_o;
  logic [31:0] ins_i, ins_o;
  logic        brch_i, mem_w_en_i, wb_sel_i, reg_w_en_i, fwd_wen, br_taken;
  logic        mem_w_en_o, wb_sel_o, reg_w_en_o;
  logic [4:0]  alu_ctrl_i, rdest_i, fwd_rdest, rdest_o;
  logic [11:0] bimm_i;
  logic [1:0]  div_state;

  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  ysyx_22041071_ex_stage dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o),
    .ready_i(ready_i), .pc_i(pc_i), .ins_i(ins_i), .brch_i(brch_i), .mem_w_en_i(mem_w_en_i),
    .wb_sel_i(wb_sel_i), .alu_ctrl_i(alu_ctrl_i), .reg_w_en_i(reg_w_en_i), .rdest_i(rdest_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .rt_data_i(rt_data_i), .bimm_i(bimm_i),
    .fwd_result(fwd_result), .fwd_wen(fwd_wen), .fwd_rdest(fwd_rdest), .br_taken(br_taken),
    .br_target(br_target), .pc_o(pc_o), .ins_o(ins_o), .mem_w_en_o(mem_w_en_o),
    .wb_sel_o(wb_sel_o), .reg_w_en_o(reg_w_en_o), .rdest_o(rdest_o), .result_o(result_o),
    .rt_data_o(rt_data_o), .div_state(div_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    valid_i = 1'b1; ins_i = 32'h0000_0033; alu_ctrl_i = op; src_a_i = a; src_b_i = b;
    reg_w_en_i = 1'b1; brch_i = 1'b0; mem_w_en_i = 1'b0; wb_sel_i = 1'b0; rdest_i = 5'd5;
    rt_data_i = 64'h55; bimm_i = 12'h0; pc_i = 64'h8000_0000;
    #1;
  endtask

  task automatic alu_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    drive(op, a, b);
    check({tag, "_fwd"}, fwd_result, exp);
    exp_q.push_back(exp);
    step();
    check({tag, "_res"}, result_o, exp_q.pop_front());
    check({tag, "_vld"}, {63'b0, valid_o}, 64'd1);
  endtask

  task automatic div_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int exp_low, input logic [63:0] exp);
    int low;
    drive(op, a, b);
    check({tag, "_fwen"}, {63'b0, fwd_wen}, 64'd0);
    low = 0;
    while (ready_o == 1'b0 && low < 200) begin
      low++;
      step();
    end
    check({tag, "_low"}, 64'(low), 64'(exp_low));
    check({tag, "_fwd"}, fwd_result, exp);
    exp_q.push_back(exp);
    step();
    check({tag, "_res"}, result_o, exp_q.pop_front());
    check({tag, "_vld"}, {63'b0, valid_o}, 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; ready_i = 1'b1; valid_i = 1'b0; ins_i = '0; alu_ctrl_i = '0; src_a_i = '0;
    src_b_i = '0; reg_w_en_i = 1'b0; brch_i = 1'b0; mem_w_en_i = 1'b0; wb_sel_i = 1'b0;
    rdest_i = '0; rt_data_i = '0; bimm_i = '0; pc_i = '0;
    step(); step();
    check("rst_valid", {63'b0, valid_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_ins", {32'b0, ins_o}, 64'd0);
    check("rst_state", {62'b0, div_state}, 64'd0);
    reset = 1'b0;

    drive(ALU_ADD, 64'd5, -64'sd7);
    check("add_ready", {63'b0, ready_o}, 64'd1);
    check("add_fwen", {63'b0, fwd_wen}, 64'd1);
    step();
    check("add_res", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
    check("add_vld", {63'b0, valid_o}, 64'd1);
    check("add_rd", {59'b0, rdest_o}, 64'd5);

    alu_op("sraw", ALU_SRAW, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
    alu_op("sllw", ALU_SLLW, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000);
    alu_op("srlw", ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000);
    alu_op("sra", ALU_SRA, 64'h8000_0000_0000_0000, 64'h44, 64'hF800_0000_0000_0000);
    alu_op("sub", ALU_SUB, 64'd10, 64'd3, 64'd7);
    alu_op("slt", ALU_SLT, -64'sd1, 64'd1, 64'd1);
    alu_op("sltu", ALU_SLTU, -64'sd1, 64'd1, 64'd0);
    alu_op("addw", ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    alu_op("mul", ALU_MUL, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003);
    alu_op("mulw", ALU_MULW, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000);

    // Branches
    drive(ALU_BLTU, 64'd1, -64'sd1);
    brch_i = 1'b1; reg_w_en_i = 1'b0; pc_i = 64'h8000_0010; bimm_i = 12'h008;
    #1;
    check("bltu_taken", {63'b0, br_taken}, 64'd1);
    check("bltu_tgt", br_target, 64'h8000_0020);
    step();
    check("bltu_res", result_o, 64'd0);
    drive(ALU_BEQ, 64'd1, 64'd2);
    brch_i = 1'b1;
    #1;
    check("beq_taken", {63'b0, br_taken}, 64'd0);
    step();
    drive(ALU_BGE, -64'sd1, 64'd1);
    brch_i = 1'b1;
    #1;
    check("bge_taken", {63'b0, br_taken}, 64'd0);
    step();

    // Downstream back-pressure
    alu_op("pre_hold", ALU_OR, 64'hF0, 64'h0F, 64'hFF);
    ready_i = 1'b0;
    drive(ALU_ADD, 64'd1, 64'd1);
    check("hold_ready", {63'b0, ready_o}, 64'd0);
    step();
    check("hold_res", result_o, 64'hFF);
    check("hold_vld", {63'b0, valid_o}, 64'd1);
    ready_i = 1'b1;
    #1;
    step();
    check("hold_rel", result_o, 64'd2);

    // Bubble
    drive(ALU_ADD, 64'd0, 64'd0);
    ins_i = 32'h0; reg_w_en_i = 1'b0;
    #1;
    check("bub_fwen", {63'b0, fwd_wen}, 64'd0);
    step();
    check("bub_vld", {63'b0, valid_o}, 64'd1);
    check("bub_wen", {63'b0, reg_w_en_o}, 64'd0);
    check("bub_ins", {32'b0, ins_o}, 64'd0);

    // Divider
    div_op("div", ALU_DIV, -64'sd20, 64'd3, 65, -64'sd6);
    div_op("rem", ALU_REM, -64'sd20, 64'd3, 65, -64'sd2);
    div_op("divw", ALU_DIVW, -64'sd20, 64'd3, 33, -64'sd6);
    div_op("divu0", ALU_DIVU, 64'd7, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    div_op("remw0", ALU_REMW, 64'd5, 64'd0, 1, 64'd5);
    div_op("ovf", ALU_DIV, 64'h8000_0000_0000_0000, -64'sd1, 65, 64'h8000_0000_0000_0000);

    // Result held in DONE while MEM is blocked, then registered exactly once
    ready_i = 1'b0;
    drive(ALU_DIVU, 64'd100, 64'd7);
    n = 0;
    while (div_state != DIV_DONE && n < 200) begin
      n++;
      step();
    end
    check("done_reach", {62'b0, div_state}, 64'd2);
    for (int i = 0; i < 3; i++) begin
      check("done_fwd", fwd_result, 64'd14);
      check("done_rdy", {63'b0, ready_o}, 64'd0);
      step();
    end
    check("done_stay", {62'b0, div_state}, 64'd2);
    ready_i = 1'b1;
    #1;
    check("done_accept", {63'b0, ready_o}, 64'd1);
    step();
    check("done_res", result_o, 64'd14);
    check("done_vld", {63'b0, valid_o}, 64'd1);
    valid_i = 1'b0;
    step();
    check("done_once", {63'b0, valid_o}, 64'd0);
    check("done_idle", {62'b0, div_state}, 64'd0);

    // Reset while the divider is at RUN cnt=10
    drive(ALU_DIV, -64'sd20, 64'd3);
    for (int i = 0; i < 11; i++) step();
    check("abort_run", {62'b0, div_state}, 64'd1);
    reset = 1'b1; valid_i = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("abort_state", {62'b0, div_state}, 64'd0);
    check("abort_vld", {63'b0, valid_o}, 64'd0);
    check("abort_res", result_o, 64'd0);
    check("abort_rdy", {63'b0, ready_o}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
